// File: rtl/ntt_addr_seq.sv
// Self-sequencing read/twiddle/write address generator for NTT, INTT, MULT and ADDSUB passes.
// Define NTT_ADDR_SEQ_STAGE_DRAIN_EN to insert a pipeline-drain gap at each NTT/INTT stage boundary.
module ntt_addr_seq #(
   parameter int LOG_N      = 8,
   parameter int NUM_STAGES = 7,
   parameter int WLAT       = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic             stall,
   output logic             busy,
   output logic             done,
   output logic             rd_valid,
   output logic [LOG_N-1:0] a_addr,
   output logic [LOG_N-1:0] b_addr,
   output logic [LOG_N-2:0] tw_addr,
   output logic [2:0]       stage,
   output logic             wr_valid,
   output logic [LOG_N-1:0] wa_addr,
   output logic [LOG_N-1:0] wb_addr
);

   localparam int N  = 1 << LOG_N;
   localparam int TW = LOG_N - 1;

   localparam logic [1:0] M_NTT    = 2'd0;
   localparam logic [1:0] M_INTT   = 2'd1;
   localparam logic [1:0] M_MULT   = 2'd2;
   localparam logic [1:0] M_ADDSUB = 2'd3;

`ifdef NTT_ADDR_SEQ_STAGE_DRAIN_EN
   localparam bit STAGE_DRAIN = 1'b1;
`else
   localparam bit STAGE_DRAIN = 1'b0;
`endif

   typedef enum logic [2:0] {S_IDLE, S_RUN, S_GAP, S_DRAIN, S_DONE} state_t;

   typedef struct packed {
      logic             v;
      logic [LOG_N-1:0] a;
      logic [LOG_N-1:0] b;
   } wr_t;

   state_t           state;
   logic [1:0]       mode_q;
   logic [LOG_N-1:0] k_q;
   logic [2:0]       s_q;
   logic             rd_vld_q;
   logic             busy_q;
   logic             done_q;
   logic [LOG_N-1:0] a_q, b_q;
   logic [TW-1:0]    tw_q;
   logic [2:0]       stage_q;
   wr_t              dl [WLAT];

   // Counter advance: k walks one stage, s steps at each wrap.
   logic [LOG_N-1:0] k_max, k_nxt;
   logic [2:0]       s_nxt;
   logic             multi_stage, stage_last, k_wrap, is_last;

   always_comb begin
      multi_stage = (mode_q == M_NTT) || (mode_q == M_INTT);
      k_max       = (mode_q == M_ADDSUB) ? {LOG_N{1'b1}} : {1'b0, {(LOG_N-1){1'b1}}};
      stage_last  = multi_stage ? (s_q == 3'(NUM_STAGES-1)) : 1'b1;
      k_wrap      = (k_q == k_max);
      is_last     = k_wrap && stage_last;
      k_nxt       = k_wrap ? '0 : k_q + LOG_N'(1);
      s_nxt       = k_wrap ? s_q + 3'd1 : s_q;
   end

   // Address calculation for the next issue (k=0,s=0 on start; held counters on leaving GAP).
   logic [1:0]       c_mode;
   logic [LOG_N-1:0] c_k;
   logic [2:0]       c_s, c_d;
   logic [LOG_N-1:0] c_len, c_grp, c_j, c_a, c_b;
   logic [TW-1:0]    c_tw;

   always_comb begin
      c_mode = (state == S_IDLE) ? mode : mode_q;
      c_k    = k_nxt;
      c_s    = s_nxt;
      if (state == S_IDLE) begin
         c_k = '0;
         c_s = '0;
      end else if (state == S_GAP) begin
         c_k = k_q;
         c_s = s_q;
      end
      c_d   = (c_mode == M_INTT) ? 3'(NUM_STAGES-1) - c_s : c_s;
      c_len = LOG_N'(1) << (LOG_N - 1 - int'(c_d));
      c_grp = c_k >> (LOG_N - 1 - int'(c_d));
      c_j   = c_k & (c_len - LOG_N'(1));
      c_a   = c_k;
      c_b   = c_k;
      c_tw  = '0;
      case (c_mode)
         M_NTT: begin
            c_a  = (c_grp << (LOG_N - int'(c_d))) | c_j;
            c_b  = c_a | c_len;
            c_tw = (TW'(1) << c_d) + TW'(c_grp);
         end
         M_INTT: begin
            c_a  = (c_grp << (LOG_N - int'(c_d))) | c_j;
            c_b  = c_a | c_len;
            // 2^(d+1) wraps to 0 at the top stage; the modular subtract still lands right.
            c_tw = (TW'(1) << (c_d + 3'd1)) - TW'(1) - TW'(c_grp);
         end
         M_MULT: begin
            c_a  = {c_k[LOG_N-2:0], 1'b0};
            c_b  = {c_k[LOG_N-2:0], 1'b1};
            c_tw = TW'(N / 4) + TW'(c_k >> 1);
         end
         default: begin
            c_a  = c_k;
            c_b  = c_k;
            c_tw = '0;
         end
      endcase
   end

   // True while something is still due to reach the write port after the next shift.
   logic pend;
   always_comb begin
      pend = rd_vld_q;
      for (int i = 0; i < WLAT - 1; i++) pend = pend | dl[i].v;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         mode_q   <= '0;
         k_q      <= '0;
         s_q      <= '0;
         rd_vld_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         tw_q     <= '0;
         stage_q  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  mode_q   <= mode;
                  k_q      <= '0;
                  s_q      <= '0;
                  a_q      <= c_a;
                  b_q      <= c_b;
                  tw_q     <= c_tw;
                  stage_q  <= '0;
                  rd_vld_q <= 1'b1;
                  busy_q   <= 1'b1;
                  state    <= S_RUN;
               end
            end
            S_RUN: begin
               if (!stall) begin
                  if (is_last) begin
                     rd_vld_q <= 1'b0;
                     state    <= S_DRAIN;
                  end else if (STAGE_DRAIN && k_wrap && multi_stage) begin
                     k_q      <= k_nxt;
                     s_q      <= s_nxt;
                     rd_vld_q <= 1'b0;
                     state    <= S_GAP;
                  end else begin
                     k_q      <= k_nxt;
                     s_q      <= s_nxt;
                     a_q      <= c_a;
                     b_q      <= c_b;
                     tw_q     <= c_tw;
                     stage_q  <= s_nxt;
                     rd_vld_q <= 1'b1;
                  end
               end
            end
            S_GAP: begin
               if (!stall && !pend) begin
                  a_q      <= c_a;
                  b_q      <= c_b;
                  tw_q     <= c_tw;
                  stage_q  <= s_q;
                  rd_vld_q <= 1'b1;
                  state    <= S_RUN;
               end
            end
            S_DRAIN: begin
               if (!stall && !pend) begin
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                  state  <= S_DONE;
               end
            end
            default: begin
               done_q <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < WLAT; i++) dl[i] <= '0;
      end else if (!stall) begin
         dl[0] <= '{v: rd_vld_q, a: a_q, b: b_q};
         for (int i = 1; i < WLAT; i++) dl[i] <= dl[i-1];
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign rd_valid = rd_vld_q & ~stall;
   assign a_addr   = a_q;
   assign b_addr   = b_q;
   assign tw_addr  = tw_q;
   assign stage    = stage_q;
   assign wr_valid = dl[WLAT-1].v & ~stall;
   assign wa_addr  = dl[WLAT-1].a;
   assign wb_addr  = dl[WLAT-1].b;

endmodule

// File: tb/tb_ntt_addr_seq.sv
// Directed bench for ntt_addr_seq: reset, NTT/INTT/MULT/ADDSUB traces, stall and ignored starts.
module tb_ntt_addr_seq;

   localparam int LOG_N = 8;
   localparam int NUM_STAGES = 7;
   localparam int WLAT = 10;
`ifdef NTT_ADDR_SEQ_STAGE_DRAIN_EN
   localparam int GAPC = 60;
`else
   localparam int GAPC = 0;
`endif

   logic             clk = 1'b0;
   logic             rst, start, stall;
   logic [1:0]       mode;
   logic             busy, done, rd_valid, wr_valid;
   logic [LOG_N-1:0] a_addr, b_addr, wa_addr, wb_addr;
   logic [LOG_N-2:0] tw_addr;
   logic [2:0]       stage;

   always #5 clk = ~clk;

   ntt_addr_seq #(.LOG_N(LOG_N), .NUM_STAGES(NUM_STAGES), .WLAT(WLAT)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .stall(stall),
      .busy(busy), .done(done), .rd_valid(rd_valid),
      .a_addr(a_addr), .b_addr(b_addr), .tw_addr(tw_addr), .stage(stage),
      .wr_valid(wr_valid), .wa_addr(wa_addr), .wb_addr(wb_addr)
   );

   typedef struct {
      int c;
      int a;
      int b;
      int tw;
      int st;
   } ev_t;

   ev_t rdq[$];
   ev_t wrq[$];
   int  checks = 0;
   int  errors = 0;
   int  cyc, done_cyc, done_cnt, busy_cnt, stall_viol;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One pass from a start pulse to done (or cycle budget); cycle 1 is the first after start.
   task automatic run_pass(input logic [1:0] m, input int stall_at, input int stall_len,
                           input int start_again, input int max_cyc);
      ev_t e;
      rdq.delete();
      wrq.delete();
      done_cyc = -1; done_cnt = 0; busy_cnt = 0; stall_viol = 0;
      @(posedge clk);
      #1 mode = m; start = 1'b1; cyc = 0;
      while (done_cyc < 0 && cyc < max_cyc) begin
         @(posedge clk);
         cyc++;
         #1;
         start = (cyc == start_again);
         stall = (cyc >= stall_at) && (cyc < stall_at + stall_len);
         mode  = m ^ 2'b01;
         @(negedge clk);
         if (stall && (rd_valid || wr_valid)) stall_viol++;
         if (busy) busy_cnt++;
         if (rd_valid) begin
            e.c = cyc; e.a = int'(a_addr); e.b = int'(b_addr); e.tw = int'(tw_addr); e.st = int'(stage);
            rdq.push_back(e);
         end
         if (wr_valid) begin
            e.c = cyc; e.a = int'(wa_addr); e.b = int'(wb_addr); e.tw = 0; e.st = 0;
            wrq.push_back(e);
         end
         if (done) begin
            done_cyc = cyc;
            done_cnt++;
         end
      end
      @(posedge clk);
      #1 start = 1'b0; stall = 1'b0;
      chk("pass_completed", int'(done_cyc >= 0), 1);
   endtask

   // Reference butterfly ordering written as the usual nested len/start/j loops.
   task automatic check_ntt_model(input string tag);
      int k = 1, idx = 0, bad = 0, s = 0;
      for (int len = 128; len >= 2; len >>= 1) begin
         for (int st = 0; st < 256; st += 2 * len) begin
            for (int j = st; j < st + len; j++) begin
               if (idx >= rdq.size()) bad++;
               else if (rdq[idx].a != j || rdq[idx].b != j + len || rdq[idx].tw != k || rdq[idx].st != s) bad++;
               idx++;
            end
            k++;
         end
         s++;
      end
      chk(tag, bad, 0);
   endtask

   task automatic check_intt_model();
      int k = 127, idx = 0, bad = 0, s = 0;
      for (int len = 2; len <= 128; len <<= 1) begin
         for (int st = 0; st < 256; st += 2 * len) begin
            for (int j = st; j < st + len; j++) begin
               if (idx >= rdq.size()) bad++;
               else if (rdq[idx].a != j || rdq[idx].b != j + len || rdq[idx].tw != k || rdq[idx].st != s) bad++;
               idx++;
            end
            k--;
         end
         s++;
      end
      chk("intt_model", bad, 0);
   endtask

   initial begin
      int bad;
      rst = 1'b1; start = 1'b0; stall = 1'b0; mode = 2'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ctrl", int'({rd_valid, wr_valid, busy, done, stage}), 0);
      chk("reset_addr", int'(a_addr | b_addr | wa_addr | wb_addr | LOG_N'(tw_addr)), 0);
      @(negedge clk) rst = 1'b0;

      // Reset in the middle of an NTT
      @(posedge clk);
      #1 mode = 2'd0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (299) @(posedge clk);
      #1 chk("mid_busy_before_rst", int'(busy), 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_ctrl", int'({rd_valid, wr_valid, busy, done, stage}), 0);
      chk("mid_rst_addr", int'(a_addr | b_addr | wa_addr | wb_addr | LOG_N'(tw_addr)), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (done || busy || rd_valid || wr_valid) bad++;
      end
      chk("mid_rst_quiet", bad, 0);

      // NTT, no stall
      run_pass(2'd0, -1, 0, -1, 2000);
      chk("ntt_first_cyc", rdq[0].c, 1);
      chk("ntt_first_a", rdq[0].a, 0);
      chk("ntt_first_b", rdq[0].b, 128);
      chk("ntt_first_tw", rdq[0].tw, 1);
      chk("ntt_first_stage", rdq[0].st, 0);
      chk("ntt_s1k0", rdq[128].a * 65536 + rdq[128].b * 256 + rdq[128].tw, 0 * 65536 + 64 * 256 + 2);
      chk("ntt_s1k64", rdq[192].a * 65536 + rdq[192].b * 256 + rdq[192].tw, 128 * 65536 + 192 * 256 + 3);
      chk("ntt_rd_count", rdq.size(), 896);
      chk("ntt_wr_count", wrq.size(), 896);
      chk("ntt_last_rd_cyc", rdq[rdq.size()-1].c, 896 + GAPC);
      chk("ntt_last_wr_cyc", wrq[wrq.size()-1].c, 906 + GAPC);
      chk("ntt_done_cyc", done_cyc, 907 + GAPC);
      chk("ntt_busy_cycles", busy_cnt, 906 + GAPC);
      check_ntt_model("ntt_model");

      // INTT
      run_pass(2'd1, -1, 0, -1, 2000);
      chk("intt_i0", rdq[0].a * 65536 + rdq[0].b * 256 + rdq[0].tw, 0 * 65536 + 2 * 256 + 127);
      chk("intt_i1", rdq[1].a * 65536 + rdq[1].b * 256 + rdq[1].tw, 1 * 65536 + 3 * 256 + 127);
      chk("intt_i2", rdq[2].a * 65536 + rdq[2].b * 256 + rdq[2].tw, 4 * 65536 + 6 * 256 + 126);
      chk("intt_last_k32", rdq[800].a * 65536 + rdq[800].b * 256 + rdq[800].tw, 32 * 65536 + 160 * 256 + 1);
      chk("intt_last_stage", rdq[800].st, 6);
      check_intt_model();
      bad = 0;
      if (wrq.size() != rdq.size()) bad++;
      else
         for (int i = 0; i < wrq.size(); i++)
            if (wrq[i].c != rdq[i].c + 10 || wrq[i].a != rdq[i].a || wrq[i].b != rdq[i].b) bad++;
      chk("intt_wr_shift", bad, 0);

      // MULT, with a start pulse landing on the DONE cycle
      run_pass(2'd2, -1, 0, 139, 2000);
      chk("mult_count", rdq.size(), 128);
      chk("mult_k3", rdq[3].a * 65536 + rdq[3].b * 256 + rdq[3].tw, 6 * 65536 + 7 * 256 + 65);
      chk("mult_k127", rdq[127].a * 65536 + rdq[127].b * 256 + rdq[127].tw, 254 * 65536 + 255 * 256 + 127);
      chk("mult_done_cyc", done_cyc, 139);
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (busy || rd_valid) bad++;
      end
      chk("start_on_done_ignored", bad, 0);

      // ADDSUB
      run_pass(2'd3, -1, 0, -1, 2000);
      chk("addsub_count", rdq.size(), 256);
      chk("addsub_k200", rdq[200].a * 65536 + rdq[200].b * 256 + rdq[200].tw, 200 * 65536 + 200 * 256 + 0);
      chk("addsub_done_cyc", done_cyc, 267);

      // NTT with a 5-cycle stall at cycle 50 and a start pulse while busy
      run_pass(2'd0, 50, 5, 100, 2000);
      chk("stall_no_valid", stall_viol, 0);
      chk("stall_pre_cyc", rdq[48].c, 49);
      chk("stall_resume_cyc", rdq[49].c, 55);
      chk("stall_resume_k49", rdq[49].a * 65536 + rdq[49].b * 256 + rdq[49].tw, 49 * 65536 + 177 * 256 + 1);
      chk("stall_wr_resume", wrq[39].c * 256 + wrq[39].a, 55 * 256 + 39);
      chk("stall_rd_count", rdq.size(), 896);
      chk("stall_done_cyc", done_cyc, 912 + GAPC);
      chk("stall_done_pulses", done_cnt, 1);
      check_ntt_model("stall_ntt_model");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
